// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory stage: op arguments from decode, data-bus
// request/response bundles, FSM state encoding and the byte-strobe helper.
package mem_access_unit_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic {
    UNSIGNED = 1'b0,
    SIGNED   = 1'b1
  } sign_t;

  typedef logic [3:0] strobe_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } mem_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    sign_t                 sig;
    msize_t                msize;
    logic [BUS_DATA_W-1:0] data;
  } memory_args_t;

  // The part of memory_args_t the unit keeps while an op is in flight.
  typedef struct packed {
    logic                  write;
    sign_t                 sig;
    msize_t                msize;
    logic [BUS_DATA_W-1:0] data;
  } mem_op_t;

  typedef struct packed {
    logic                  valid;
    logic [BUS_ADDR_W-1:0] addr;
    msize_t                size;
    strobe_t               strobe;
    logic [BUS_DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                  addr_ok;
    logic                  data_ok;
    logic [BUS_DATA_W-1:0] data;
  } dbus_resp_t;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic strobe_t msize_strobe(msize_t msize, logic [1:0] addr_lo);
    case (msize)
      MSIZE1:  return strobe_t'(4'b0001 << addr_lo);
      MSIZE2:  return strobe_t'(4'b0011 << {addr_lo[1], 1'b0});
      MSIZE4:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [1:0] align_mask(msize_t msize);
    case (msize)
      MSIZE2:  return 2'b01;
      MSIZE4:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: shifts the addressed bytes of a bus word down to bit 0 and
// sign- or zero-extends sub-word results.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  addr_lo_i,
  input  msize_t      msize_i,
  input  sign_t       sig_i,
  output logic [31:0] word_o
);

  logic [31:0] shifted;
  logic        ext_byte;
  logic        ext_half;

  assign shifted  = raw_i >> {addr_lo_i, 3'b000};
  assign ext_byte = (sig_i == SIGNED) & shifted[7];
  assign ext_half = (sig_i == SIGNED) & shifted[15];

  // Select the extension matching the access size.
  always_comb begin
    case (msize_i)
      MSIZE1:  word_o = {{24{ext_byte}}, shifted[7:0]};
      MSIZE2:  word_o = {{16{ext_half}}, shifted[15:0]};
      default: word_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: accepts one op at a time, issues a single data-bus request,
// returns extended load data (0 for stores / non-memory ops) and holds it
// until writeback accepts it.
// Optional: define MEM_ALIGN_CHECK_EN to trap misaligned accesses on
// out_adel/out_ades instead of silently masking the offending address bits.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W  // 4 byte lanes; only 32 is supported
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  memory_args_t       args,
  input  logic [ADDR_W-1:0]  addr,
  output dbus_req_t          dreq,
  input  dbus_resp_t         dresp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic               out_adel,
  output logic               out_ades
`endif
);

  mem_state_t        state_q, state_d;
  mem_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [31:0]       load_word;
  logic [DATA_W-1:0] done_word;
`ifdef MEM_ALIGN_CHECK_EN
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;
  logic              misaligned;

  assign misaligned = |(addr[1:0] & align_mask(args.msize));
`endif

  mem_load_align u_load_align (
    .raw_i     (dresp.data),
    .addr_lo_i (addr_q[1:0]),
    .msize_i   (op_q.msize),
    .sig_i     (op_q.sig),
    .word_o    (load_word)
  );

  // Stores complete with a zero result; loads return the extended word.
  assign done_word = op_q.write ? '0 : load_word;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef MEM_ALIGN_CHECK_EN
      adel_q  <= adel_d;
      ades_q  <= ades_d;
`endif
    end
  end

  // Next-state logic: accept, bus handshake, result capture, writeback handoff.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef MEM_ALIGN_CHECK_EN
    adel_d  = adel_q;
    ades_d  = ades_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = '{write: args.write, sig: args.sig, msize: args.msize, data: args.data};
          data_d = '0;
`ifdef MEM_ALIGN_CHECK_EN
          addr_d = addr;
          adel_d = 1'b0;
          ades_d = 1'b0;
          if (!args.valid) begin
            state_d = DONE;
          end else if (misaligned) begin
            // Trap without touching the bus.
            state_d = DONE;
            adel_d  = !args.write;
            ades_d  = args.write;
          end else begin
            state_d = REQ;
          end
`else
          // Misaligned addresses are forced to the enclosing aligned slot.
          addr_d  = {addr[ADDR_W-1:2], addr[1:0] & ~align_mask(args.msize)};
          state_d = args.valid ? REQ : DONE;
`endif
        end
      end
      REQ: begin
        if (dresp.addr_ok) begin
          if (dresp.data_ok) begin
            state_d = DONE;
            data_d  = done_word;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dresp.data_ok) begin
          state_d = DONE;
          data_d  = done_word;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state; the bus request is only driven in REQ.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = data_q;
    dreq      = '0;
    if (state_q == REQ) begin
      dreq.valid  = 1'b1;
      dreq.addr   = addr_q;
      dreq.size   = op_q.msize;
      dreq.strobe = op_q.write ? msize_strobe(op_q.msize, addr_q[1:0]) : '0;
      dreq.data   = op_q.data << {addr_q[1:0], 3'b000};
    end
`ifdef MEM_ALIGN_CHECK_EN
    out_adel  = adel_q;
    out_ades  = ades_q;
`endif
  end

endmodule
